// File: rtl/nmi_pkg.sv
// Shared types and constants for the NMI arbiter: FSM states, default
// timing, and the fixed source slots on the NMI line.
package nmi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_INSIDE = 3'd3,
    ST_EXIT   = 3'd4
  } state_t;

  localparam int NSRC_DEF      = 4;
  localparam int PULSE_LEN_DEF = 16;
  localparam int EXIT_RFSH_DEF = 3;

  // Source slots; a lower index wins when several are pending.
  localparam int SRC_BUTTON = 0;
  localparam int SRC_SPI    = 1;
  localparam int SRC_DBG    = 2;
  localparam int SRC_SW     = 3;

endpackage

// File: rtl/nmi_arbiter_if.sv
// Bus between the system (zports/slavespi/clock generator) and the NMI
// arbiter. The system side is the master, the arbiter is the slave.
//
// Signalling: there is no valid/ready pair on this bus. int_start and
// clr_nmi are single-cycle strobes taken on the fclk edge where they are
// high. zpos && !rfsh_n marks one refresh cycle. req is level; only its
// rising edge (while mask is set) counts as a request. Every output is
// valid on every cycle with no handshake. state is a read-only debug view
// of the arbiter FSM.
interface nmi_arbiter_if #(
  parameter int NSRC = 4
);
  import nmi_pkg::*;

  logic            zpos;
  logic            rfsh_n;
  logic            int_start;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] mask;
  logic            clr_nmi;
  logic            gen_nmi;
  logic            in_nmi;
  logic [NSRC-1:0] nmi_cause;
  logic [NSRC-1:0] pending;
  logic            busy;
  state_t          state;

  modport master (
    output zpos, rfsh_n, int_start, req, mask, clr_nmi,
    input  gen_nmi, in_nmi, nmi_cause, pending, busy, state
  );

  modport slave (
    input  zpos, rfsh_n, int_start, req, mask, clr_nmi,
    output gen_nmi, in_nmi, nmi_cause, pending, busy, state
  );

endinterface

// File: rtl/nmi_prio_enc.sv
// Fixed-priority one-hot encoder: the lowest set bit of req wins.
module nmi_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic [NSRC-1:0] grant
);

  // Walk from index 0 upward and keep only the first set bit.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nmi_arbiter.sv
// Shares the Z80 NMI line between several requesters. Requests are edge
// latched per source, one is chosen by fixed priority at the frame INT,
// the NMI pulse is driven for PULSE_LEN fclk cycles, and in_nmi (page-0
// remap) is held until the CPU writes the clear port and EXIT_RFSH refresh
// cycles have passed.
module nmi_arbiter
  import nmi_pkg::*;
#(
  parameter int NSRC      = NSRC_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int EXIT_RFSH = EXIT_RFSH_DEF
) (
  input  logic          fclk,
  input  logic          rst,
  nmi_arbiter_if.slave  bus
);

  state_t          state_q, state_d;
  logic [NSRC-1:0] req_r;
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] grant;
  logic [NSRC-1:0] grant_clr;
  logic [NSRC-1:0] cause_q, cause_d;
  logic [7:0]      pulse_cnt_q, pulse_cnt_d;
  logic [2:0]      exit_cnt_q, exit_cnt_d;
  logic            in_nmi_q, in_nmi_d;
  logic            rfsh_tick;

  // A request that rises while its source is masked is simply lost.
  assign rise      = bus.req & ~req_r & bus.mask;
  assign rfsh_tick = bus.zpos & ~bus.rfsh_n;

  nmi_prio_enc #(
    .NSRC (NSRC)
  ) u_prio (
    .req   (pending_q),
    .grant (grant)
  );

  // State, counters and request latches; everything clears on rst.
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_r       <= '0;
      pending_q   <= '0;
      cause_q     <= '0;
      pulse_cnt_q <= '0;
      exit_cnt_q  <= '0;
      in_nmi_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_r       <= bus.req;
      pending_q   <= (pending_q | rise) & bus.mask & ~grant_clr;
      cause_q     <= cause_d;
      pulse_cnt_q <= pulse_cnt_d;
      exit_cnt_q  <= exit_cnt_d;
      in_nmi_q    <= in_nmi_d;
    end
  end

  // Next state, counter updates and grant. The grant looks only at the
  // registered pending vector, so a request rising on the int_start cycle
  // waits for the following frame.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    pulse_cnt_d = pulse_cnt_q;
    exit_cnt_d  = exit_cnt_q;
    in_nmi_d    = in_nmi_q;
    grant_clr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (bus.int_start && (|pending_q)) begin
          cause_d     = grant;
          grant_clr   = grant;
          in_nmi_d    = 1'b1;
          pulse_cnt_d = 8'(PULSE_LEN);
          state_d     = ST_PULSE;
        end else if (!(|pending_q)) begin
          state_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q != 8'd0) pulse_cnt_d = pulse_cnt_q - 8'd1;
        if (pulse_cnt_q <= 8'd1) state_d = ST_INSIDE;
      end
      ST_INSIDE: begin
        if (bus.clr_nmi) begin
          exit_cnt_d = 3'(EXIT_RFSH);
          state_d    = ST_EXIT;
        end
      end
      ST_EXIT: begin
        // A repeated clear restarts the refresh countdown.
        if (bus.clr_nmi) begin
          exit_cnt_d = 3'(EXIT_RFSH);
        end else if (rfsh_tick) begin
          if (exit_cnt_q <= 3'd1) begin
            exit_cnt_d = 3'd0;
            in_nmi_d   = 1'b0;
            state_d    = (|pending_q) ? ST_ARMED : ST_IDLE;
          end else begin
            exit_cnt_d = exit_cnt_q - 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // gen_nmi is gated by rst so the NMI line releases without waiting for
  // the reset edge.
  assign bus.gen_nmi   = (state_q == ST_PULSE) && (pulse_cnt_q != 8'd0) && !rst;
  assign bus.in_nmi    = in_nmi_q;
  assign bus.nmi_cause = cause_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.state     = state_q;

endmodule
